// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle ARM-subset control unit.
//   state_t  : FSM state encoding (also driven out on the debug state port)
//   OP_*     : instr[27:26] instruction classes
//   COND_*   : instr[31:28] condition codes
//   ALU_*    : alu_control operation codes
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_MEMWB  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_FAULT  = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_MOV = 4'b1101;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator.
//   cond    : instr[31:28]
//   flags   : registered {N,Z,C,V}
//   cond_ex : 1 when the instruction should execute (1111 never executes)
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Control unit for the multi-cycle ARM-subset datapath.
// Inputs : IR fields (cond/op/funct/rd), ALU flags, memory ready handshake.
// Outputs: every datapath mux select / write enable, ALU op, BL/BX strobes,
//          registered NZCV flags, debug state, sticky memory-timeout fault.
// Control outputs are decoded combinationally from the current state and IR
// fields and are held at 0 while rst_n is low.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ALUCTL_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int BL_LINK_REG = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          cond,
  input  logic [1:0]          op,
  input  logic [5:0]          funct,
  input  logic [3:0]          rd,
  input  logic [3:0]          alu_nzcv,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_write,
  output logic                adr_src,
  output logic                alu_src_a,
  output logic [1:0]          imm_src,
  output logic [1:0]          reg_src,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                bl_enable,
  output logic                bx_enable,
  output logic [3:0]          link_rd,
  output logic [3:0]          flags,
  output logic [3:0]          state,
  output logic                mem_fault
);

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex;

  cond_check u_cond (.cond(cond), .flags(flags_q), .cond_ex(cond_ex));

  logic       is_cmp, is_wait, wait_miss, timeout;
  logic [3:0] dp_alu;
  assign is_cmp    = (funct[4:1] == ALU_CMP);
  assign dp_alu    = is_cmp ? ALU_SUB : funct[4:1];
  assign is_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign wait_miss = is_wait && !mem_ready;
  // Fault on the MEM_TIMEOUT-th consecutive miss; a ready on that cycle completes normally.
  assign timeout   = wait_miss && (cnt_q == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    cnt_d     = (wait_miss && !timeout) ? cnt_q + 8'd1 : 8'd0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        cond_ex_d = cond_ex;
        if (!cond_ex)          state_d = S_FETCH;
        else if (op == OP_DP)  state_d = S_EXEC;
        else if (op == OP_MEM) state_d = S_MEMADR;
        else if (op == OP_BR)  state_d = S_BRANCH;
        else                   state_d = S_FETCH;
      end
      S_EXEC: begin
        state_d = S_ALUWB;
        if (funct[0] || is_cmp) flags_d = alu_nzcv;
      end
      S_ALUWB:  state_d = S_FETCH;
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_MEMWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'd0;
      cnt_q     <= 8'd0;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Write strobes past DECODE are qualified by the latched condition result.
  always_comb begin
    mem_req = 1'b0; pc_write = 1'b0; ir_write = 1'b0; mem_write = 1'b0;
    reg_write = 1'b0; adr_src = 1'b0; alu_src_a = 1'b0; bl_enable = 1'b0;
    bx_enable = 1'b0; imm_src = 2'b00; reg_src = 2'b00; alu_src_b = 2'b00;
    result_src = 2'b00; alu_control = '0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1; alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
          alu_control = ALUCTL_W'(ALU_ADD);
          ir_write = mem_ready; pc_write = mem_ready;
        end
        S_DECODE: begin
          imm_src = op;
          reg_src = (op == OP_MEM) ? 2'b10 : (op == OP_BR) ? 2'b01 : 2'b00;
        end
        S_EXEC: begin
          alu_src_b   = funct[5] ? 2'b01 : 2'b00;
          alu_control = ALUCTL_W'(dp_alu);
        end
        S_ALUWB: begin
          alu_control = ALUCTL_W'(dp_alu);
          reg_write   = cond_ex_q && !is_cmp;
          pc_write    = cond_ex_q && !is_cmp && (rd == 4'd15);
        end
        S_MEMADR: begin
          alu_src_b = 2'b01; alu_control = ALUCTL_W'(ALU_ADD);
        end
        S_MEMRD: begin
          mem_req = 1'b1; adr_src = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1; adr_src = 1'b1; mem_write = cond_ex_q;
        end
        S_MEMWB: begin
          reg_write = cond_ex_q; result_src = 2'b01;
          pc_write  = cond_ex_q && (rd == 4'd15);
        end
        S_BRANCH: begin
          pc_write = cond_ex_q; alu_src_b = 2'b01; result_src = 2'b10; imm_src = 2'b10;
          alu_control = ALUCTL_W'(ALU_MOV);
          bl_enable = cond_ex_q && (funct[5:4] == 2'b10);
          reg_write = bl_enable;
          bx_enable = cond_ex_q && (funct[5:4] == 2'b11);
        end
        default: ;
      endcase
    end
  end

  assign link_rd   = 4'(BL_LINK_REG);
  assign flags     = flags_q;
  assign state     = state_q;
  assign mem_fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench: each stimulus cycle pushes its expected outputs;
// the negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl_fsm;

  logic       clk, rst_n;
  logic [3:0] cond, rd, alu_nzcv;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req, pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a;
  logic [1:0] imm_src, reg_src, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic       bl_enable, bx_enable, mem_fault;
  logic [3:0] link_rd, flags, state;

  multicycle_ctrl_fsm #(.ALUCTL_W(4), .MEM_TIMEOUT(15), .BL_LINK_REG(14)) dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_nzcv(alu_nzcv), .mem_ready(mem_ready), .mem_req(mem_req),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .imm_src(imm_src), .reg_src(reg_src), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_control(alu_control), .bl_enable(bl_enable),
    .bx_enable(bx_enable), .link_rd(link_rd), .flags(flags), .state(state),
    .mem_fault(mem_fault));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [20:0] c;
    logic [3:0] fl;
    logic       flt;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_chk = 0, n_err = 0;

  logic [20:0] act_c;
  assign act_c = {mem_req, pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
                  bl_enable, bx_enable, imm_src, reg_src, alu_src_b, result_src, alu_control};

  // {mreq pcw irw mw rw adr asa bl bx | imm rsrc asb rsl | alu}
  function automatic logic [20:0] cv(input logic mq, pw, iw, mw, rw, ad, aa, bl, bx,
                                     input logic [1:0] im, rs, ab, rl, input logic [3:0] al);
    return {mq, pw, iw, mw, rw, ad, aa, bl, bx, im, rs, ab, rl, al};
  endfunction
  function automatic logic [20:0] fv(input logic r);
    return cv(1, r, r, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 4'b0100);
  endfunction
  function automatic logic [20:0] dv(input logic [1:0] im, rs);
    return cv(0, 0, 0, 0, 0, 0, 0, 0, 0, im, rs, 2'b00, 2'b00, 4'b0000);
  endfunction

  task automatic chk(input string n, input logic [20:0] a, input logic [20:0] x);
    n_chk++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk({me.nm, ".state"}, 21'(state), 21'(me.st));
      chk({me.nm, ".ctrl"},  act_c, me.c);
      chk({me.nm, ".flags"}, 21'(flags), 21'(me.fl));
      chk({me.nm, ".fault"}, 21'(mem_fault), 21'(me.flt));
    end
  end

  task automatic ir(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                    input logic [3:0] r, input logic [3:0] nz);
    cond = c; op = o; funct = f; rd = r; alu_nzcv = nz;
  endtask

  task automatic cyc(input string nm, input logic rdy, input logic rstn, input logic [3:0] st,
                     input logic [20:0] c, input logic [3:0] fl, input logic flt);
    exp_t e;
    mem_ready = rdy; rst_n = rstn;
    e.nm = nm; e.st = st; e.c = c; e.fl = fl; e.flt = flt;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  localparam logic [20:0] Z = 21'd0;
  localparam logic [20:0] MRD = 21'b1_0_0_0_0_1_0_0_0_00_00_00_00_0000;
  localparam logic [20:0] MWR = 21'b1_0_0_1_0_1_0_0_0_00_00_00_00_0000;
  localparam logic [20:0] MAD = 21'b0_0_0_0_0_0_0_0_0_00_00_01_00_0100;

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0;
    ir(4'h0, 2'b00, 6'd0, 4'd0, 4'd0);
    @(posedge clk); #1;
    cyc("rst0", 0, 0, 4'd0, Z, 4'h0, 0);
    cyc("rst1", 1, 0, 4'd0, Z, 4'h0, 0);

    // ADDS R1,R2,R3 -> flags 0100 on ALUWB entry
    ir(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100);
    cyc("adds.f", 1, 1, 4'd0, fv(1), 4'h0, 0);
    cyc("adds.d", 1, 1, 4'd1, dv(2'b00, 2'b00), 4'h0, 0);
    cyc("adds.e", 1, 1, 4'd6, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'b0100), 4'h0, 0);
    cyc("adds.w", 1, 1, 4'd7, cv(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'b0100), 4'b0100, 0);

    // ADD PC,R2,#imm, S=0: flags unchanged, pc_write with reg_write
    ir(4'hE, 2'b00, 6'b101000, 4'd15, 4'b1011);
    cyc("addpc.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("addpc.d", 1, 1, 4'd1, dv(2'b00, 2'b00), 4'b0100, 0);
    cyc("addpc.e", 1, 1, 4'd6, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,4'b0100), 4'b0100, 0);
    cyc("addpc.w", 1, 1, 4'd7, cv(0,1,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'b0100), 4'b0100, 0);

    // CMP #imm, Z clear -> flags 0010, no reg_write, ALU forced SUB
    ir(4'hE, 2'b00, 6'b110101, 4'd0, 4'b0010);
    cyc("cmp1.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("cmp1.d", 1, 1, 4'd1, dv(2'b00, 2'b00), 4'b0100, 0);
    cyc("cmp1.e", 1, 1, 4'd6, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,4'b0010), 4'b0100, 0);
    cyc("cmp1.w", 1, 1, 4'd7, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'b0010), 4'b0010, 0);

    // BEQ with Z clear: 2 cycles, no pc_write
    ir(4'h0, 2'b10, 6'b000000, 4'd0, 4'b1111);
    cyc("beqn.f", 1, 1, 4'd0, fv(1), 4'b0010, 0);
    cyc("beqn.d", 1, 1, 4'd1, dv(2'b10, 2'b01), 4'b0010, 0);

    // Never-condition ADDS: skipped, flags untouched
    ir(4'hF, 2'b00, 6'b001001, 4'd1, 4'b1111);
    cyc("nv.f", 1, 1, 4'd0, fv(1), 4'b0010, 0);
    cyc("nv.d", 1, 1, 4'd1, dv(2'b00, 2'b00), 4'b0010, 0);

    // CMP with Z set -> flags 0100
    ir(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
    cyc("cmp2.f", 1, 1, 4'd0, fv(1), 4'b0010, 0);
    cyc("cmp2.d", 1, 1, 4'd1, dv(2'b00, 2'b00), 4'b0010, 0);
    cyc("cmp2.e", 1, 1, 4'd6, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'b0010), 4'b0010, 0);
    cyc("cmp2.w", 1, 1, 4'd7, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'b0010), 4'b0100, 0);

    // BEQ taken
    ir(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    cyc("beqt.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("beqt.d", 1, 1, 4'd1, dv(2'b10, 2'b01), 4'b0100, 0);
    cyc("beqt.b", 1, 1, 4'd8, cv(0,1,0,0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b10,4'b1101), 4'b0100, 0);

    // BGT with Z set: not taken
    ir(4'hC, 2'b10, 6'b000000, 4'd0, 4'b0000);
    cyc("bgt.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("bgt.d", 1, 1, 4'd1, dv(2'b10, 2'b01), 4'b0100, 0);

    // BGE with N==V: taken
    ir(4'hA, 2'b10, 6'b000000, 4'd0, 4'b0000);
    cyc("bge.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("bge.d", 1, 1, 4'd1, dv(2'b10, 2'b01), 4'b0100, 0);
    cyc("bge.b", 1, 1, 4'd8, cv(0,1,0,0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b10,4'b1101), 4'b0100, 0);

    // BL: link write
    ir(4'hE, 2'b10, 6'b100000, 4'd0, 4'b0000);
    cyc("bl.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("bl.d", 1, 1, 4'd1, dv(2'b10, 2'b01), 4'b0100, 0);
    cyc("bl.b", 1, 1, 4'd8, cv(0,1,0,0,1,0,0,1,0,2'b10,2'b00,2'b01,2'b10,4'b1101), 4'b0100, 0);

    // BX: register branch, no reg_write
    ir(4'hE, 2'b10, 6'b110000, 4'd0, 4'b0000);
    cyc("bx.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("bx.d", 1, 1, 4'd1, dv(2'b10, 2'b01), 4'b0100, 0);
    cyc("bx.b", 1, 1, 4'd8, cv(0,1,0,0,0,0,0,0,1,2'b10,2'b00,2'b01,2'b10,4'b1101), 4'b0100, 0);

    // LDR R2 with 3 MEMRD wait cycles: 8 cycles total
    ir(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000);
    cyc("ldr.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("ldr.d", 1, 1, 4'd1, dv(2'b01, 2'b10), 4'b0100, 0);
    cyc("ldr.a", 1, 1, 4'd2, MAD, 4'b0100, 0);
    for (int i = 0; i < 3; i++) cyc("ldr.rwait", 0, 1, 4'd3, MRD, 4'b0100, 0);
    cyc("ldr.r", 1, 1, 4'd3, MRD, 4'b0100, 0);
    cyc("ldr.wb", 1, 1, 4'd5, cv(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b01,4'b0000), 4'b0100, 0);

    // LDR PC: 2 fetch waits, then ready on the 15th MEMRD cycle (no fault)
    ir(4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    for (int i = 0; i < 2; i++) cyc("ldrpc.fwait", 0, 1, 4'd0, fv(0), 4'b0100, 0);
    cyc("ldrpc.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("ldrpc.d", 1, 1, 4'd1, dv(2'b01, 2'b10), 4'b0100, 0);
    cyc("ldrpc.a", 1, 1, 4'd2, MAD, 4'b0100, 0);
    for (int i = 0; i < 14; i++) cyc("ldrpc.rwait", 0, 1, 4'd3, MRD, 4'b0100, 0);
    cyc("ldrpc.r15", 1, 1, 4'd3, MRD, 4'b0100, 0);
    cyc("ldrpc.wb", 1, 1, 4'd5, cv(0,1,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b01,4'b0000), 4'b0100, 0);

    // STR R3: 4 cycles
    ir(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
    cyc("str.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("str.d", 1, 1, 4'd1, dv(2'b01, 2'b10), 4'b0100, 0);
    cyc("str.a", 1, 1, 4'd2, MAD, 4'b0100, 0);
    cyc("str.w", 1, 1, 4'd4, MWR, 4'b0100, 0);

    // STR interrupted by reset in MEMWR
    cyc("strr.f", 1, 1, 4'd0, fv(1), 4'b0100, 0);
    cyc("strr.d", 1, 1, 4'd1, dv(2'b01, 2'b10), 4'b0100, 0);
    cyc("strr.a", 1, 1, 4'd2, MAD, 4'b0100, 0);
    cyc("strr.w", 0, 1, 4'd4, MWR, 4'b0100, 0);
    cyc("strr.rst0", 1, 0, 4'd0, Z, 4'h0, 0);
    cyc("strr.rst1", 1, 0, 4'd0, Z, 4'h0, 0);
    ir(4'hF, 2'b01, 6'b011000, 4'd3, 4'b0000);
    cyc("post.f", 1, 1, 4'd0, fv(1), 4'h0, 0);
    cyc("post.d", 1, 1, 4'd1, dv(2'b01, 2'b10), 4'h0, 0);

    // STR with memory never ready: 15 waits, then sticky FAULT
    ir(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
    cyc("sto.f", 1, 1, 4'd0, fv(1), 4'h0, 0);
    cyc("sto.d", 1, 1, 4'd1, dv(2'b01, 2'b10), 4'h0, 0);
    cyc("sto.a", 1, 1, 4'd2, MAD, 4'h0, 0);
    for (int i = 0; i < 15; i++) cyc("sto.wait", 0, 1, 4'd4, MWR, 4'h0, 0);
    for (int i = 0; i < 3; i++) cyc("sto.fault", 1, 1, 4'd9, Z, 4'h0, 1);
    cyc("sto.rst", 1, 0, 4'd0, Z, 4'h0, 0);
    ir(4'hF, 2'b00, 6'b000000, 4'd0, 4'b0000);
    cyc("rec.f", 1, 1, 4'd0, fv(1), 4'h0, 0);
    cyc("rec.d", 1, 1, 4'd1, dv(2'b00, 2'b00), 4'h0, 0);
    cyc("rec.f2", 1, 1, 4'd0, fv(1), 4'h0, 0);

    chk("link_rd", 21'(link_rd), 21'd14);
    chk("queue_drained", 21'(q.size()), 21'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
